pipe_hazard_ctrl: RTL and testbench

//  Second-generation hazard/pipeline control for the 5-stage MIPS core on the sram-like bus.
//  - Generalises operand count and register-index width.
//  - Adds a post-exception fetch-drain FSM that discards the stale in-flight instruction response.
//  - Adds a bus-stall watchdog.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/hazard_src_match.sv | 39 +++
 rtl/pipe_hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings for the hazard/pipeline controller
package hazard_pkg;
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_W    = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;

  localparam int ST_F = 0;
  localparam int ST_D = 1;
  localparam int ST_E = 2;
  localparam int ST_M = 3;
  localparam int ST_W = 4;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;
endpackage

// File: rtl/hazard_src_match.sv
// rtl/hazard_src_match.sv - per-operand register comparators for forwarding and hazard detection
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter int RW = 5
) (
  input  logic [RW-1:0] src_d,
  input  logic          src_d_vld,
  input  logic [RW-1:0] src_e,
  input  logic [RW-1:0] dst_e,
  input  logic [RW-1:0] dst_m,
  input  logic [RW-1:0] dst_w,
  input  logic          regwrite_e,
  input  logic          regwrite_m,
  input  logic          regwrite_w,
  input  logic          memtoreg_m,
  input  logic          late_result_e,
  input  logic          branch,
  output logic [1:0]    fwd_e,
  output logic          fwd_d,
  output logic          lu,
  output logic          br
);
  logic d_hits_e, d_hits_m, e_hits_m, e_hits_w;

  // Register 0 is hard-wired zero, so it never creates a dependency.
  assign d_hits_e = (src_d != '0) && (src_d == dst_e);
  assign d_hits_m = (src_d != '0) && (src_d == dst_m);
  assign e_hits_m = (src_e != '0) && (src_e == dst_m);
  assign e_hits_w = (src_e != '0) && (src_e == dst_w);

  assign fwd_e = (e_hits_m && regwrite_m) ? FWD_M :
                 (e_hits_w && regwrite_w) ? FWD_W : FWD_NONE;
  assign fwd_d = d_hits_m && regwrite_m && !memtoreg_m;

  assign lu = src_d_vld && late_result_e && regwrite_e && d_hits_e;
  assign br = src_d_vld && branch &&
              ((regwrite_e && d_hits_e) || (memtoreg_m && d_hits_m));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/forwarding control with fetch-drain FSM and bus-stall watchdog
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int NSRC          = 2,
  parameter int RW            = 5,
  parameter int STALL_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 inst_stall,
  input  logic                 inst_req_pend,
  input  logic [NSRC*RW-1:0]   src_d,
  input  logic [NSRC-1:0]      src_d_vld,
  input  logic                 branch_d,
  input  logic                 jr_d,
  input  logic [NSRC*RW-1:0]   src_e,
  input  logic [RW-1:0]        dst_e,
  input  logic                 regwrite_e,
  input  logic                 memtoreg_e,
  input  logic                 hilotoreg_e,
  input  logic                 cp0toreg_e,
  input  logic                 div_stall_e,
  input  logic [RW-1:0]        dst_m,
  input  logic                 regwrite_m,
  input  logic                 memtoreg_m,
  input  logic                 except_m,
  input  logic                 data_stall,
  input  logic [RW-1:0]        dst_w,
  input  logic                 regwrite_w,
  output logic [NSRC-1:0]      fwd_d,
  output logic [NSRC*2-1:0]    fwd_e,
  output logic [4:0]           stall,
  output logic [4:0]           flush,
  output logic                 discard_inst,
  output logic                 long_stall,
  output logic                 stall_timeout,
  output logic [31:0]          perf_lu_cnt,
  output logic [31:0]          perf_bus_cnt
);
  state_t          state;
  logic [NSRC-1:0] lu_v, br_v;
  logic            lu_any, other;

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    hazard_src_match #(.RW(RW)) u_match (
      .src_d         (src_d[g*RW +: RW]),
      .src_d_vld     (src_d_vld[g]),
      .src_e         (src_e[g*RW +: RW]),
      .dst_e         (dst_e),
      .dst_m         (dst_m),
      .dst_w         (dst_w),
      .regwrite_e    (regwrite_e),
      .regwrite_m    (regwrite_m),
      .regwrite_w    (regwrite_w),
      .memtoreg_m    (memtoreg_m),
      .late_result_e (memtoreg_e | hilotoreg_e | cp0toreg_e),
      .branch        (branch_d | jr_d),
      .fwd_e         (fwd_e[g*2 +: 2]),
      .fwd_d         (fwd_d[g]),
      .lu            (lu_v[g]),
      .br            (br_v[g])
    );
  end

  assign lu_any       = |lu_v;
  assign long_stall   = inst_stall | data_stall | div_stall_e;
  assign other        = (lu_any | (|br_v)) & ~except_m & (state == S_IDLE);
  assign discard_inst = (state == S_DRAIN);

  always_comb begin
    stall          = {5{long_stall}};
    stall[ST_D:ST_F] = {2{long_stall | other}};
    flush          = '0;
    flush[ST_E]    = other & ~long_stall;
    // While draining, hold fetch and kill whatever decode captured.
    if (state == S_DRAIN) begin
      stall[ST_F] = 1'b1;
      flush[ST_D] = 1'b1;
    end
    if (except_m) flush = '1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (except_m && inst_req_pend) state <= S_DRAIN;
        S_DRAIN: if (!except_m && !inst_req_pend) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  if (STALL_TIMEOUT > 0) begin : g_wdog
    localparam int CW = $clog2(STALL_TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STALL_TIMEOUT);
    logic [CW-1:0] run_cnt, run_nxt;
    logic          timeout_q;

    // The counter includes the current stall cycle, so the flag rises on the edge closing the last one.
    always_comb begin
      run_nxt = '0;
      if (long_stall) run_nxt = (run_cnt == LIMIT) ? LIMIT : run_cnt + CW'(1);
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        run_cnt   <= '0;
        timeout_q <= 1'b0;
      end else begin
        run_cnt <= run_nxt;
        if (run_nxt == LIMIT) timeout_q <= 1'b1;
      end
    end
    assign stall_timeout = timeout_q;
  end else begin : g_no_wdog
    assign stall_timeout = 1'b0;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] lu_cnt_q, bus_cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lu_cnt_q  <= '0;
      bus_cnt_q <= '0;
    end else begin
      if (other && lu_any && lu_cnt_q != 32'hFFFF_FFFF) lu_cnt_q <= lu_cnt_q + 32'd1;
      if (long_stall && bus_cnt_q != 32'hFFFF_FFFF) bus_cnt_q <= bus_cnt_q + 32'd1;
    end
  end
  assign perf_lu_cnt  = lu_cnt_q;
  assign perf_bus_cnt = bus_cnt_q;
`else
  assign perf_lu_cnt  = 32'd0;
  assign perf_bus_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed bench with a per-cycle reference model for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  localparam int NSRC = 2;
  localparam int RW   = 5;
  localparam int TO   = 8;

  logic            clk, resetn;
  logic            inst_stall, inst_req_pend, branch_d, jr_d;
  logic [9:0]      src_d, src_e;
  logic [1:0]      src_d_vld;
  logic [4:0]      dst_e, dst_m, dst_w;
  logic            regwrite_e, memtoreg_e, hilotoreg_e, cp0toreg_e, div_stall_e;
  logic            regwrite_m, memtoreg_m, except_m, data_stall, regwrite_w;
  logic [1:0]      fwd_d;
  logic [3:0]      fwd_e;
  logic [4:0]      stall, flush;
  logic            discard_inst, long_stall, stall_timeout;
  logic [31:0]     perf_lu_cnt, perf_bus_cnt;

  int checks   = 0;
  int failures = 0;

  pipe_hazard_ctrl #(.NSRC(NSRC), .RW(RW), .STALL_TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .inst_stall(inst_stall), .inst_req_pend(inst_req_pend),
    .src_d(src_d), .src_d_vld(src_d_vld), .branch_d(branch_d), .jr_d(jr_d),
    .src_e(src_e), .dst_e(dst_e), .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e),
    .hilotoreg_e(hilotoreg_e), .cp0toreg_e(cp0toreg_e), .div_stall_e(div_stall_e),
    .dst_m(dst_m), .regwrite_m(regwrite_m), .memtoreg_m(memtoreg_m), .except_m(except_m),
    .data_stall(data_stall), .dst_w(dst_w), .regwrite_w(regwrite_w),
    .fwd_d(fwd_d), .fwd_e(fwd_e), .stall(stall), .flush(flush),
    .discard_inst(discard_inst), .long_stall(long_stall), .stall_timeout(stall_timeout),
    .perf_lu_cnt(perf_lu_cnt), .perf_bus_cnt(perf_bus_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pipeline bookkeeping in plain terms.
  bit m_drain, m_timed_out;
  int m_run, m_lu_cycles, m_bus_cycles;
  logic [4:0] e_stall, e_flush;
  logic [3:0] e_fwd_e;
  logic [1:0] e_fwd_d;
  bit e_ls, e_hazard, e_lu;

  always_comb begin
    bit br_any;
    int sd, se;
    e_ls = inst_stall | data_stall | div_stall_e;
    e_lu = 0; br_any = 0; e_fwd_e = '0; e_fwd_d = '0;
    sd = 0; se = 0;
    for (int i = 0; i < NSRC; i++) begin
      sd = int'(src_d[i*RW +: RW]);
      se = int'(src_e[i*RW +: RW]);
      if (se != 0 && se == int'(dst_m) && regwrite_m) e_fwd_e[i*2 +: 2] = 2'd2;
      else if (se != 0 && se == int'(dst_w) && regwrite_w) e_fwd_e[i*2 +: 2] = 2'd1;
      e_fwd_d[i] = (sd != 0) && sd == int'(dst_m) && regwrite_m && !memtoreg_m;
      if (src_d_vld[i] && sd != 0) begin
        if (sd == int'(dst_e) && regwrite_e && (memtoreg_e | hilotoreg_e | cp0toreg_e)) e_lu = 1;
        if ((branch_d | jr_d) && sd == int'(dst_e) && regwrite_e) br_any = 1;
        if ((branch_d | jr_d) && sd == int'(dst_m) && memtoreg_m) br_any = 1;
      end
    end
    e_hazard = (e_lu | br_any) && !except_m && !m_drain;
    e_stall = e_ls ? 5'b11111 : 5'b00000;
    if (e_hazard) e_stall = e_stall | 5'b00011;
    e_flush = (e_hazard && !e_ls) ? 5'b00100 : 5'b00000;
    if (m_drain) begin
      e_stall = e_stall | 5'b00001;
      e_flush = e_flush | 5'b00010;
    end
    if (except_m) e_flush = 5'b11111;
  end

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_drain <= 0; m_timed_out <= 0; m_run <= 0; m_lu_cycles <= 0; m_bus_cycles <= 0;
    end else begin
      if (except_m) m_drain <= m_drain || inst_req_pend;
      else if (!inst_req_pend) m_drain <= 0;
      if (e_ls) begin
        m_run <= m_run + 1;
        if (m_run + 1 >= TO) m_timed_out <= 1;
      end else begin
        m_run <= 0;
      end
`ifdef HAZARD_PERF_CNT_EN
      if (e_hazard && e_lu) m_lu_cycles <= m_lu_cycles + 1;
      if (e_ls) m_bus_cycles <= m_bus_cycles + 1;
`endif
    end
  end

  always @(negedge clk) begin
    if (resetn) begin
      chk("stall",         32'(stall),         32'(e_stall));
      chk("flush",         32'(flush),         32'(e_flush));
      chk("fwd_e",         32'(fwd_e),         32'(e_fwd_e));
      chk("fwd_d",         32'(fwd_d),         32'(e_fwd_d));
      chk("discard_inst",  32'(discard_inst),  32'(m_drain));
      chk("long_stall",    32'(long_stall),    32'(e_ls));
      chk("stall_timeout", 32'(stall_timeout), 32'(m_timed_out));
      chk("perf_lu_cnt",   perf_lu_cnt,        32'(m_lu_cycles));
      chk("perf_bus_cnt",  perf_bus_cnt,       32'(m_bus_cycles));
    end
  end

  task automatic clr();
    inst_stall = 0; inst_req_pend = 0; branch_d = 0; jr_d = 0;
    src_d = '0; src_e = '0; src_d_vld = '0; dst_e = '0; dst_m = '0; dst_w = '0;
    regwrite_e = 0; memtoreg_e = 0; hilotoreg_e = 0; cp0toreg_e = 0; div_stall_e = 0;
    regwrite_m = 0; memtoreg_m = 0; except_m = 0; data_stall = 0; regwrite_w = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 0;
    clr();
    #1;
    chk("rst_stall",   32'(stall),         32'h0);
    chk("rst_flush",   32'(flush),         32'h0);
    chk("rst_discard", 32'(discard_inst),  32'h0);
    chk("rst_timeout", 32'(stall_timeout), 32'h0);
    chk("rst_perf_lu", perf_lu_cnt,        32'h0);
    cyc(2);
    resetn = 1;
    cyc(1);

    // Load-use on operand 0, operand 1 independent.
    dst_e = 5'd2; memtoreg_e = 1; regwrite_e = 1; src_d = {5'd5, 5'd2}; src_d_vld = 2'b11;
    #1;
    chk("lu_stall", 32'(stall), 32'h03);
    chk("lu_flush", 32'(flush), 32'h04);
    cyc(3);
    memtoreg_e = 0;
    #1;
    chk("lu_clear_stall", 32'(stall), 32'h00);
    chk("lu_clear_flush", 32'(flush), 32'h00);

    clr();
    inst_stall = 1;
    #1;
    chk("bus_stall", 32'(stall), 32'h1F);
    cyc(5);
    clr();
    #1;
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_lu_3",  perf_lu_cnt,  32'd3);
    chk("perf_bus_5", perf_bus_cnt, 32'd5);
`else
    chk("perf_lu_off",  perf_lu_cnt,  32'd0);
    chk("perf_bus_off", perf_bus_cnt, 32'd0);
`endif
    cyc(1);

    // M result wins over W for the same register; r0 never forwards.
    dst_m = 5'd3; regwrite_m = 1; dst_w = 5'd3; regwrite_w = 1; src_e = {5'd0, 5'd3};
    #1;
    chk("fwd_prio", 32'(fwd_e), 32'h2);
    cyc(1);
    regwrite_m = 0;
    #1;
    chk("fwd_w", 32'(fwd_e), 32'h1);
    cyc(1);

    clr();
    branch_d = 1; src_d = {5'd0, 5'd4}; src_d_vld = 2'b01; dst_e = 5'd4; regwrite_e = 1;
    #1;
    chk("br_stall", 32'(stall), 32'h03);
    cyc(1);
    except_m = 1;
    #1;
    chk("br_exc_stall", 32'(stall), 32'h00);
    chk("br_exc_flush", 32'(flush), 32'h1F);
    cyc(1);
    chk("br_exc_nodrain", 32'(discard_inst), 32'h0);

    clr();
    except_m = 1; inst_req_pend = 1;
    #1;
    chk("exc_flush", 32'(flush), 32'h1F);
    cyc(1);
    except_m = 0;
    #1;
    chk("drain_discard", 32'(discard_inst), 32'h1);
    chk("drain_stall",   32'(stall),        32'h01);
    chk("drain_flush",   32'(flush),        32'h02);
    cyc(2);
    except_m = 1;
    #1;
    chk("drain_exc_flush", 32'(flush), 32'h1F);
    cyc(1);
    except_m = 0; inst_req_pend = 0;
    #1;
    chk("drain_last", 32'(discard_inst), 32'h1);
    cyc(1);
    chk("drain_exit", 32'(discard_inst), 32'h0);

    // Reset while draining drops back to IDLE without a clock.
    except_m = 1; inst_req_pend = 1;
    cyc(1);
    except_m = 0;
    #1;
    chk("pre_rst_discard", 32'(discard_inst), 32'h1);
    resetn = 0;
    #1;
    chk("rst_drain_discard", 32'(discard_inst), 32'h0);
    cyc(1);
    resetn = 1;
    clr();
    cyc(1);

    data_stall = 1;
    cyc(7);
    data_stall = 0;
    cyc(1);
    chk("wdog_7", 32'(stall_timeout), 32'h0);
    data_stall = 1;
    cyc(8);
    data_stall = 0;
    #1;
    chk("wdog_8", 32'(stall_timeout), 32'h1);
    cyc(3);
    chk("wdog_sticky", 32'(stall_timeout), 32'h1);

    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
